// File: rtl/merge_select_2_pkg.sv
// Shared types for the 2-merger front end: element/tuple widths, merge state
// encoding and a tuple lead-element accessor.
package merge_pkg;

    localparam int W  = 32;
    localparam int TW = 2 * W;

    typedef enum logic [1:0] {
        MERGE   = 2'd0,
        DRAIN_A = 2'd1,
        DRAIN_B = 2'd2,
        SWITCH  = 2'd3
    } merge_state_e;

    // Tuples are stored sorted, so the low element is the smallest one.
    function automatic logic [W-1:0] lead_elem(input logic [TW-1:0] tuple);
        return tuple[W-1:0];
    endfunction

endpackage

// File: rtl/merge_select_2_if.sv
// Tuple-stream bus between the two FWFT input FIFOs, merge_select_2 and the
// bitonic network. Stats signals exist only when MERGE_SELECT_STATS_EN is defined.
interface merge_select_2_if;
    import merge_pkg::*;

    logic [TW-1:0] a_data;
    logic          a_empty;
    logic          a_last;
    logic          a_rd_en;
    logic [TW-1:0] b_data;
    logic          b_empty;
    logic          b_last;
    logic          b_rd_en;
    logic          out_stall;
    logic [TW-1:0] elems;
    logic [TW-1:0] top_tuple;
    logic          stall;
    logic          switch_output;
`ifdef MERGE_SELECT_STATS_EN
    logic [31:0]   a_count;
    logic [31:0]   b_count;
    logic [31:0]   stall_count;
    logic [31:0]   a_count_last;
    logic [31:0]   b_count_last;
    logic [31:0]   stall_count_last;
`endif

    modport slave (
        input  a_data, a_empty, a_last, b_data, b_empty, b_last, out_stall,
`ifdef MERGE_SELECT_STATS_EN
        output a_count, b_count, stall_count, a_count_last, b_count_last, stall_count_last,
`endif
        output a_rd_en, b_rd_en, elems, top_tuple, stall, switch_output
    );

    modport master (
        output a_data, a_empty, a_last, b_data, b_empty, b_last, out_stall,
`ifdef MERGE_SELECT_STATS_EN
        input  a_count, b_count, stall_count, a_count_last, b_count_last, stall_count_last,
`endif
        input  a_rd_en, b_rd_en, elems, top_tuple, stall, switch_output
    );

endinterface

// File: rtl/merge_select_2_cmp.sv
// Combinational pop selection for a 2-way merge: eligibility, lead-element
// compare with ties to A, and survivor-only popping while draining.
module merge_select_cmp
    import merge_pkg::*;
(
    input  merge_state_e   state,
    input  logic           stall_req,
    input  logic           a_empty,
    input  logic           a_done,
    input  logic           b_empty,
    input  logic           b_done,
    input  logic [W-1:0]   a_lead,
    input  logic [W-1:0]   b_lead,
    output logic           pop_a,
    output logic           pop_b
);

    logic a_elig_s;
    logic b_elig_s;

    assign a_elig_s = ~a_empty & ~a_done;
    assign b_elig_s = ~b_empty & ~b_done;

    // Select at most one stream to pop this cycle
    always_comb begin
        pop_a = 1'b0;
        pop_b = 1'b0;
        if (stall_req) begin
            pop_a = 1'b0;
            pop_b = 1'b0;
        end else begin
            case (state)
                MERGE: begin
                    if (a_elig_s && b_elig_s) begin
                        if (a_lead <= b_lead) begin
                            pop_a = 1'b1;
                        end else begin
                            pop_b = 1'b1;
                        end
                    end else begin
                        pop_a = 1'b0;
                        pop_b = 1'b0;
                    end
                end
                DRAIN_A: pop_a = a_elig_s;
                DRAIN_B: pop_b = b_elig_s;
                SWITCH: begin
                    pop_a = 1'b0;
                    pop_b = 1'b0;
                end
                default: begin
                    pop_a = 1'b0;
                    pop_b = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/merge_select_2.sv
// 2-merger front end: pops the smaller-lead stream, registers tuples onto the
// network input, drains the survivor and toggles job parity. Optional per-job
// statistics are enabled with MERGE_SELECT_STATS_EN.
module merge_select_2
    import merge_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    merge_select_2_if.slave  bus
);

    merge_state_e  state_r;
    merge_state_e  state_nxt_s;
    logic          a_done_r;
    logic          b_done_r;
    logic          a_done_nxt_s;
    logic          b_done_nxt_s;
    logic          pop_a_s;
    logic          pop_b_s;
    logic          pop_any_s;
    logic [TW-1:0] pop_data_s;
    logic [TW-1:0] elems_r;
    logic [TW-1:0] top_tuple_r;
    logic          stall_r;
    logic          switch_r;

    merge_select_cmp u_cmp (
        .state     (state_r),
        .stall_req (bus.out_stall),
        .a_empty   (bus.a_empty),
        .a_done    (a_done_r),
        .b_empty   (bus.b_empty),
        .b_done    (b_done_r),
        .a_lead    (lead_elem(bus.a_data)),
        .b_lead    (lead_elem(bus.b_data)),
        .pop_a     (pop_a_s),
        .pop_b     (pop_b_s)
    );

    assign pop_any_s  = pop_a_s | pop_b_s;
    assign pop_data_s = pop_a_s ? bus.a_data : bus.b_data;

    // Job sequencing: a stream finishing in MERGE hands over to draining the other
    always_comb begin
        state_nxt_s  = state_r;
        a_done_nxt_s = a_done_r;
        b_done_nxt_s = b_done_r;
        case (state_r)
            MERGE: begin
                if (pop_a_s && bus.a_last) begin
                    a_done_nxt_s = 1'b1;
                    state_nxt_s  = DRAIN_B;
                end else if (pop_b_s && bus.b_last) begin
                    b_done_nxt_s = 1'b1;
                    state_nxt_s  = DRAIN_A;
                end else begin
                    state_nxt_s  = MERGE;
                end
            end
            DRAIN_A: begin
                if (pop_a_s && bus.a_last) begin
                    a_done_nxt_s = 1'b1;
                    state_nxt_s  = SWITCH;
                end else begin
                    state_nxt_s  = DRAIN_A;
                end
            end
            DRAIN_B: begin
                if (pop_b_s && bus.b_last) begin
                    b_done_nxt_s = 1'b1;
                    state_nxt_s  = SWITCH;
                end else begin
                    state_nxt_s  = DRAIN_B;
                end
            end
            SWITCH: begin
                a_done_nxt_s = 1'b0;
                b_done_nxt_s = 1'b0;
                state_nxt_s  = MERGE;
            end
            default: begin
                a_done_nxt_s = 1'b0;
                b_done_nxt_s = 1'b0;
                state_nxt_s  = MERGE;
            end
        endcase
    end

    // State and per-stream done flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= MERGE;
            a_done_r <= 1'b0;
            b_done_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            a_done_r <= a_done_nxt_s;
            b_done_r <= b_done_nxt_s;
        end
    end

    // Issue registers: data holds on every no-pop cycle, stall reports it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            elems_r     <= {TW{1'b0}};
            top_tuple_r <= {TW{1'b0}};
            stall_r     <= 1'b1;
        end else if (pop_any_s) begin
            elems_r     <= pop_data_s;
            top_tuple_r <= elems_r;
            stall_r     <= 1'b0;
        end else begin
            stall_r     <= 1'b1;
        end
    end

    // Job parity flips once per SWITCH bubble
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            switch_r <= 1'b0;
        end else if (state_r == SWITCH) begin
            switch_r <= ~switch_r;
        end else begin
            switch_r <= switch_r;
        end
    end

    assign bus.a_rd_en       = pop_a_s;
    assign bus.b_rd_en       = pop_b_s;
    assign bus.elems         = elems_r;
    assign bus.top_tuple     = top_tuple_r;
    assign bus.stall         = stall_r;
    assign bus.switch_output = switch_r;

`ifdef MERGE_SELECT_STATS_EN
    logic [31:0] a_cnt_r;
    logic [31:0] b_cnt_r;
    logic [31:0] stall_cnt_r;
    logic [31:0] a_cnt_last_r;
    logic [31:0] b_cnt_last_r;
    logic [31:0] stall_cnt_last_r;
    logic [31:0] a_cnt_inc_s;
    logic [31:0] b_cnt_inc_s;
    logic [31:0] stall_cnt_inc_s;
    logic        switch_entry_s;

    assign switch_entry_s  = (state_nxt_s == SWITCH) && (state_r != SWITCH);
    assign a_cnt_inc_s     = a_cnt_r + {31'd0, pop_a_s};
    assign b_cnt_inc_s     = b_cnt_r + {31'd0, pop_b_s};
    assign stall_cnt_inc_s = stall_cnt_r + {31'd0, (stall_r && (state_r != SWITCH))};

    // Per-job counters; the closing cycle's increment is included in the snapshot
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_cnt_r          <= 32'd0;
            b_cnt_r          <= 32'd0;
            stall_cnt_r      <= 32'd0;
            a_cnt_last_r     <= 32'd0;
            b_cnt_last_r     <= 32'd0;
            stall_cnt_last_r <= 32'd0;
        end else if (switch_entry_s) begin
            a_cnt_last_r     <= a_cnt_inc_s;
            b_cnt_last_r     <= b_cnt_inc_s;
            stall_cnt_last_r <= stall_cnt_inc_s;
            a_cnt_r          <= 32'd0;
            b_cnt_r          <= 32'd0;
            stall_cnt_r      <= 32'd0;
        end else begin
            a_cnt_r          <= a_cnt_inc_s;
            b_cnt_r          <= b_cnt_inc_s;
            stall_cnt_r      <= stall_cnt_inc_s;
        end
    end

    assign bus.a_count          = a_cnt_r;
    assign bus.b_count          = b_cnt_r;
    assign bus.stall_count      = stall_cnt_r;
    assign bus.a_count_last     = a_cnt_last_r;
    assign bus.b_count_last     = b_cnt_last_r;
    assign bus.stall_count_last = stall_cnt_last_r;
`endif

endmodule

// File: tb/tb_merge_select_2.sv
// Directed bench for merge_select_2: queue-backed FWFT streams and
// hand-computed expected issue sequences per scenario.
module tb_merge_select_2;
    import merge_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic force_b_empty;
    logic [TW:0] qa[$];
    logic [TW:0] qb[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    merge_select_2_if bus();

    merge_select_2 dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    function automatic logic [TW-1:0] tup(input int unsigned lo, input int unsigned hi);
        return {hi[W-1:0], lo[W-1:0]};
    endfunction

    function automatic logic [TW:0] ent(input int unsigned lo, input int unsigned hi, input logic last);
        return {last, tup(lo, hi)};
    endfunction

    task automatic drive_heads();
        logic [TW:0] h;
        h = '0;
        if (qa.size() != 0) h = qa[0];
        bus.a_empty = (qa.size() == 0);
        bus.a_data  = h[TW-1:0];
        bus.a_last  = h[TW];
        h = '0;
        if (qb.size() != 0) h = qb[0];
        bus.b_empty = (qb.size() == 0) || force_b_empty;
        bus.b_data  = h[TW-1:0];
        bus.b_last  = h[TW];
    endtask

    // Entered and left 2 time units after a rising edge.
    task automatic cycle();
        logic pa;
        logic pb;
        #1;
        pa = bus.a_rd_en;
        pb = bus.b_rd_en;
        @(posedge clk);
        #1;
        if (pa && qa.size() != 0) qa.delete(0);
        if (pb && qb.size() != 0) qb.delete(0);
        drive_heads();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        force_b_empty = 1'b0;
        bus.out_stall = 1'b0;
        drive_heads();
        repeat (2) @(posedge clk);
        #2;
        n_cmp++; if (bus.elems !== tup(0, 0)) begin n_err++; $display("FAIL reset_elems: got %h want 0", bus.elems); end
        n_cmp++; if (bus.top_tuple !== tup(0, 0)) begin n_err++; $display("FAIL reset_top: got %h want 0", bus.top_tuple); end
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL reset_stall: got %b want 1", bus.stall); end
        n_cmp++; if (bus.switch_output !== 1'b0) begin n_err++; $display("FAIL reset_switch: got %b want 0", bus.switch_output); end
        n_cmp++; if (dut.state_r !== MERGE) begin n_err++; $display("FAIL reset_state: got %0d want MERGE", dut.state_r); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_merge();
        logic [TW-1:0] exp [4];
        exp[0] = tup(1, 2); exp[1] = tup(3, 4); exp[2] = tup(5, 6); exp[3] = tup(7, 8);
        qa.push_back(ent(1, 2, 1'b0)); qa.push_back(ent(5, 6, 1'b1));
        qb.push_back(ent(3, 4, 1'b0)); qb.push_back(ent(7, 8, 1'b1));
        drive_heads();
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_cmp++; if (bus.elems !== exp[i]) begin n_err++; $display("FAIL basic_elems[%0d]: got %h want %h", i, bus.elems, exp[i]); end
            n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL basic_stall[%0d]: got %b want 0", i, bus.stall); end
            if (i > 0) begin
                n_cmp++; if (bus.top_tuple !== exp[i-1]) begin n_err++; $display("FAIL basic_top[%0d]: got %h want %h", i, bus.top_tuple, exp[i-1]); end
            end
            n_cmp++; if (bus.switch_output !== 1'b0) begin n_err++; $display("FAIL basic_switch_pre[%0d]: got %b want 0", i, bus.switch_output); end
        end
        n_cmp++; if (dut.state_r !== SWITCH) begin n_err++; $display("FAIL basic_state_switch: got %0d want SWITCH", dut.state_r); end
        cycle();
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL basic_bubble_stall: got %b want 1", bus.stall); end
        n_cmp++; if (bus.switch_output !== 1'b1) begin n_err++; $display("FAIL basic_switch_post: got %b want 1", bus.switch_output); end
        n_cmp++; if (dut.state_r !== MERGE) begin n_err++; $display("FAIL basic_state_merge: got %0d want MERGE", dut.state_r); end
    endtask

    task automatic test_tie();
        qa.push_back(ent(4, 9, 1'b1));
        qb.push_back(ent(4, 5, 1'b1));
        drive_heads();
        #1;
        n_cmp++; if (bus.a_rd_en !== 1'b1) begin n_err++; $display("FAIL tie_a_rd_en: got %b want 1", bus.a_rd_en); end
        n_cmp++; if (bus.b_rd_en !== 1'b0) begin n_err++; $display("FAIL tie_b_rd_en: got %b want 0", bus.b_rd_en); end
        cycle();
        n_cmp++; if (bus.elems !== tup(4, 9)) begin n_err++; $display("FAIL tie_first: got %h want %h", bus.elems, tup(4, 9)); end
        n_cmp++; if (dut.state_r !== DRAIN_B) begin n_err++; $display("FAIL tie_state: got %0d want DRAIN_B", dut.state_r); end
        cycle();
        n_cmp++; if (bus.elems !== tup(4, 5)) begin n_err++; $display("FAIL tie_second: got %h want %h", bus.elems, tup(4, 5)); end
        cycle();
        n_cmp++; if (bus.switch_output !== 1'b0) begin n_err++; $display("FAIL tie_switch: got %b want 0", bus.switch_output); end
    endtask

    task automatic test_backpressure();
        qa.push_back(ent(10, 11, 1'b0)); qa.push_back(ent(12, 13, 1'b0)); qa.push_back(ent(30, 31, 1'b1));
        qb.push_back(ent(20, 21, 1'b0)); qb.push_back(ent(22, 23, 1'b1));
        drive_heads();
        cycle();
        cycle();
        bus.out_stall = 1'b1;
        #1;
        n_cmp++; if (bus.a_rd_en !== 1'b0 || bus.b_rd_en !== 1'b0) begin n_err++; $display("FAIL bp_rd_en: got a=%b b=%b want 0 0", bus.a_rd_en, bus.b_rd_en); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++; if (bus.elems !== tup(12, 13)) begin n_err++; $display("FAIL bp_elems[%0d]: got %h want %h", i, bus.elems, tup(12, 13)); end
            n_cmp++; if (bus.top_tuple !== tup(10, 11)) begin n_err++; $display("FAIL bp_top[%0d]: got %h want %h", i, bus.top_tuple, tup(10, 11)); end
            n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL bp_stall[%0d]: got %b want 1", i, bus.stall); end
        end
        bus.out_stall = 1'b0;
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL bp_stall_fall: got %b want 1", bus.stall); end
        cycle();
        n_cmp++; if (bus.elems !== tup(20, 21) || bus.stall !== 1'b0) begin n_err++; $display("FAIL bp_resume: got %h/%b want %h/0", bus.elems, bus.stall, tup(20, 21)); end
        cycle();
        cycle();
        n_cmp++; if (bus.elems !== tup(30, 31)) begin n_err++; $display("FAIL bp_drain: got %h want %h", bus.elems, tup(30, 31)); end
        cycle();
        n_cmp++; if (bus.switch_output !== 1'b1) begin n_err++; $display("FAIL bp_switch: got %b want 1", bus.switch_output); end
    endtask

    task automatic test_early_finish();
        logic [TW-1:0] exp [4];
        exp[0] = tup(2, 3); exp[1] = tup(4, 5); exp[2] = tup(6, 7); exp[3] = tup(8, 9);
        qa.push_back(ent(1, 1, 1'b1));
        for (int i = 0; i < 4; i++) qb.push_back({(i == 3) ? 1'b1 : 1'b0, exp[i]});
        drive_heads();
        cycle();
        n_cmp++; if (bus.elems !== tup(1, 1)) begin n_err++; $display("FAIL early_a: got %h want %h", bus.elems, tup(1, 1)); end
        n_cmp++; if (dut.state_r !== DRAIN_B) begin n_err++; $display("FAIL early_state: got %0d want DRAIN_B", dut.state_r); end
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_cmp++; if (bus.elems !== exp[i] || bus.stall !== 1'b0) begin n_err++; $display("FAIL early_b[%0d]: got %h/%b want %h/0", i, bus.elems, bus.stall, exp[i]); end
        end
        cycle();
        n_cmp++; if (bus.stall !== 1'b1 || bus.switch_output !== 1'b0) begin n_err++; $display("FAIL early_switch: got stall=%b sw=%b want 1 0", bus.stall, bus.switch_output); end
    endtask

    task automatic test_empty_bubble();
        qa.push_back(ent(3, 4, 1'b0)); qa.push_back(ent(9, 9, 1'b1));
        qb.push_back(ent(5, 6, 1'b1));
        force_b_empty = 1'b1;
        drive_heads();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (bus.a_rd_en !== 1'b0 || bus.b_rd_en !== 1'b0) begin n_err++; $display("FAIL bubble_rd_en[%0d]: got a=%b b=%b want 0 0", i, bus.a_rd_en, bus.b_rd_en); end
            cycle();
            n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL bubble_stall[%0d]: got %b want 1", i, bus.stall); end
        end
        n_cmp++; if (dut.state_r !== MERGE) begin n_err++; $display("FAIL bubble_state: got %0d want MERGE", dut.state_r); end
        force_b_empty = 1'b0;
        drive_heads();
        cycle();
        n_cmp++; if (bus.elems !== tup(3, 4) || bus.stall !== 1'b0) begin n_err++; $display("FAIL bubble_pop_a: got %h/%b want %h/0", bus.elems, bus.stall, tup(3, 4)); end
        cycle();
        n_cmp++; if (bus.elems !== tup(5, 6)) begin n_err++; $display("FAIL bubble_pop_b: got %h want %h", bus.elems, tup(5, 6)); end
        cycle();
        n_cmp++; if (bus.elems !== tup(9, 9)) begin n_err++; $display("FAIL bubble_drain_a: got %h want %h", bus.elems, tup(9, 9)); end
        cycle();
        n_cmp++; if (bus.switch_output !== 1'b1) begin n_err++; $display("FAIL bubble_switch: got %b want 1", bus.switch_output); end
    endtask

    task automatic test_async_reset();
        qa.push_back(ent(7, 8, 1'b0)); qa.push_back(ent(9, 10, 1'b1));
        qb.push_back(ent(11, 12, 1'b1));
        drive_heads();
        cycle();
        n_cmp++; if (bus.elems !== tup(7, 8)) begin n_err++; $display("FAIL arst_pre: got %h want %h", bus.elems, tup(7, 8)); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL arst_stall: got %b want 1", bus.stall); end
        n_cmp++; if (bus.elems !== tup(0, 0)) begin n_err++; $display("FAIL arst_elems: got %h want 0", bus.elems); end
        n_cmp++; if (bus.switch_output !== 1'b0) begin n_err++; $display("FAIL arst_switch: got %b want 0", bus.switch_output); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (dut.state_r !== MERGE) begin n_err++; $display("FAIL arst_state: got %0d want MERGE", dut.state_r); end
        cycle();
        n_cmp++; if (bus.elems !== tup(9, 10) || bus.top_tuple !== tup(0, 0)) begin n_err++; $display("FAIL arst_first: got %h/%h want %h/0", bus.elems, bus.top_tuple, tup(9, 10)); end
        cycle();
        n_cmp++; if (bus.elems !== tup(11, 12) || bus.top_tuple !== tup(9, 10)) begin n_err++; $display("FAIL arst_second: got %h/%h want %h/%h", bus.elems, bus.top_tuple, tup(11, 12), tup(9, 10)); end
        cycle();
        n_cmp++; if (bus.switch_output !== 1'b1) begin n_err++; $display("FAIL arst_switch_post: got %b want 1", bus.switch_output); end
    endtask

    initial begin
        test_reset();
        test_basic_merge();
        test_tie();
        test_backpressure();
        test_early_finish();
        test_empty_bubble();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
